// File: rtl/status_unit_pkg.sv
// status_unit_pkg: ALU command encodings and NZCV bit positions shared by the status unit
package status_unit_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    // The legal encodings happen to form the contiguous range MOV..MVN
    function automatic logic is_legal(input logic [3:0] cmd);
        return (cmd >= CMD_MOV) && (cmd <= CMD_MVN);
    endfunction

endpackage

// File: rtl/status_unit_flag_gen.sv
// status_unit_flag_gen: combinational ALU result and NZCV flag computation
module status_unit_flag_gen
    import status_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       cmd_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_old_i,
    input  logic             v_old_i,
    output logic [3:0]       flags_o,
    output logic             legal_o
);

    logic             is_sub;
    logic             arith;
    logic             cin;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;

    // Subtracts reuse the adder with inverted b; ADC/SBC take the registered carry as carry-in
    always_comb begin
        is_sub  = (cmd_i == CMD_SUB) || (cmd_i == CMD_SBC);
        arith   = (cmd_i >= CMD_ADD) && (cmd_i <= CMD_SBC);
        cin     = (cmd_i == CMD_ADD) ? 1'b0 : (cmd_i == CMD_SUB) ? 1'b1 : c_old_i;
        op_b    = is_sub ? ~b_i : b_i;
        sum     = {1'b0, a_i} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
        r       = arith              ? sum[WIDTH-1:0] :
                  (cmd_i == CMD_MOV) ? b_i :
                  (cmd_i == CMD_MVN) ? ~b_i :
                  (cmd_i == CMD_AND) ? (a_i & b_i) :
                  (cmd_i == CMD_ORR) ? (a_i | b_i) : (a_i ^ b_i);
        flags_o        = '0;
        flags_o[N_BIT] = r[WIDTH-1];
        flags_o[Z_BIT] = ~|r;
        flags_o[C_BIT] = arith ? sum[WIDTH] : c_old_i;
        flags_o[V_BIT] = arith ? ((is_sub ? (a_i[WIDTH-1] ^ b_i[WIDTH-1]) : ~(a_i[WIDTH-1] ^ b_i[WIDTH-1]))
                                  & (r[WIDTH-1] ^ a_i[WIDTH-1])) : v_old_i;
        legal_o        = is_legal(cmd_i);
    end

endmodule

// File: rtl/status_unit.sv
// status_unit: NZCV status register with priority update mux and exception shadow copy
module status_unit
    import status_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exe_valid,
    input  logic             exe_s,
    input  logic             exe_cond_pass,
    input  logic [3:0]       exe_alu_cmd,
    input  logic [WIDTH-1:0] exe_a,
    input  logic [WIDTH-1:0] exe_b,
    input  logic             stall,
    input  logic             flush,
    input  logic             msr_we,
    input  logic [3:0]       msr_data,
    input  logic             exc_entry,
    input  logic             exc_return,
    output logic [3:0]       status,
    output logic [3:0]       status_fwd,
    output logic [3:0]       shadow,
    output logic             flag_wr
);

    logic [3:0] status_q, status_d;
    logic [3:0] shadow_q, shadow_d;
    logic       flag_wr_q, flag_wr_d;
    logic [3:0] alu_flags;
    logic       legal;
    logic       alu_upd;

    status_unit_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .cmd_i   (exe_alu_cmd),
        .a_i     (exe_a),
        .b_i     (exe_b),
        .c_old_i (status_q[C_BIT]),
        .v_old_i (status_q[V_BIT]),
        .flags_o (alu_flags),
        .legal_o (legal)
    );

    // Next-state selection: return > explicit write > ALU > hold; on a combined entry+return the shadow saves the pre-return status
    always_comb begin
        alu_upd   = exe_valid & exe_s & exe_cond_pass & legal & ~flush;
        status_d  = stall      ? status_q :
                    exc_return ? shadow_q :
                    msr_we     ? msr_data :
                    alu_upd    ? alu_flags : status_q;
        shadow_d  = (stall | ~exc_entry) ? shadow_q : exc_return ? status_q : status_d;
        flag_wr_d = stall ? flag_wr_q : (exc_return | msr_we | alu_upd);
    end

    // Architectural status, shadow and write-strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q  <= '0;
            shadow_q  <= '0;
            flag_wr_q <= 1'b0;
        end else begin
            status_q  <= status_d;
            shadow_q  <= shadow_d;
            flag_wr_q <= flag_wr_d;
        end
    end

    assign status     = status_q;
    assign status_fwd = status_d;
    assign shadow     = shadow_q;
    assign flag_wr    = flag_wr_q;

endmodule

// File: tb/tb_status_unit.sv
// tb_status_unit: directed-vector scoreboard bench for the NZCV status unit
module tb_status_unit;

    localparam logic [7:0] ALU = 8'b1110_0000;
    localparam logic [7:0] STL = 8'b0001_0000;
    localparam logic [7:0] FL  = 8'b0000_1000;
    localparam logic [7:0] MW  = 8'b0000_0100;
    localparam logic [7:0] EE  = 8'b0000_0010;
    localparam logic [7:0] ER  = 8'b0000_0001;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] sh;
        logic       fw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exe_valid = 1'b0, exe_s = 1'b0, exe_cond_pass = 1'b0;
    logic [3:0]  exe_alu_cmd = '0;
    logic [31:0] exe_a = '0, exe_b = '0;
    logic        stall = 1'b0, flush = 1'b0, msr_we = 1'b0;
    logic [3:0]  msr_data = '0;
    logic        exc_entry = 1'b0, exc_return = 1'b0;
    logic [3:0]  status, status_fwd, shadow;
    logic        flag_wr;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    status_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .exe_valid     (exe_valid),
        .exe_s         (exe_s),
        .exe_cond_pass (exe_cond_pass),
        .exe_alu_cmd   (exe_alu_cmd),
        .exe_a         (exe_a),
        .exe_b         (exe_b),
        .stall         (stall),
        .flush         (flush),
        .msr_we        (msr_we),
        .msr_data      (msr_data),
        .exc_entry     (exc_entry),
        .exc_return    (exc_return),
        .status        (status),
        .status_fwd    (status_fwd),
        .shadow        (shadow),
        .flag_wr       (flag_wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic step(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] ctl, input logic [3:0] md,
                        input logic [3:0] es, input logic [3:0] esh, input logic ef);
        @(negedge clk);
        {exe_valid, exe_s, exe_cond_pass, stall, flush, msr_we, exc_entry, exc_return} = ctl;
        exe_alu_cmd = cmd;
        exe_a       = a;
        exe_b       = b;
        msr_data    = md;
        exp_q.push_back('{st: es, sh: esh, fw: ef});
    endtask

    // Monitor: forward value checked mid-cycle, registered state checked after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) check("status_fwd", status_fwd, exp_q[0].st);
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("status", status, e.st);
                check("shadow", shadow, e.sh);
                check("flag_wr", {3'b0, flag_wr}, {3'b0, e.fw});
            end
        end
    end

    initial begin
        int waited;
        repeat (2) @(negedge clk);
        check("reset_status", status, 4'b0000);
        check("reset_shadow", shadow, 4'b0000);
        check("reset_flag_wr", {3'b0, flag_wr}, 4'b0000);
        rst_n = 1'b1;

        step(4'b0010, 32'h7FFF_FFFF, 32'h1,         ALU,        4'h0, 4'b1001, 4'b0000, 1'b1);
        step(4'b0100, 32'h5,         32'h5,         ALU,        4'h0, 4'b0110, 4'b0000, 1'b1);
        step(4'b0011, 32'hFFFF_FFFF, 32'h0,         ALU,        4'h0, 4'b0110, 4'b0000, 1'b1);
        step(4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, ALU,        4'h0, 4'b1010, 4'b0000, 1'b1);
        step(4'b0010, 32'h1,         32'h1,         8'b1100_0000, 4'h0, 4'b1010, 4'b0000, 1'b0);
        step(4'b0010, 32'h1,         32'h1,         ALU | FL,   4'h0, 4'b1010, 4'b0000, 1'b0);
        step(4'b0010, 32'h1,         32'h1,         ALU | STL,  4'h0, 4'b1010, 4'b0000, 1'b0);
        step(4'b0010, 32'h1,         32'h1,         8'b1010_0000, 4'h0, 4'b1010, 4'b0000, 1'b0);
        step(4'b1111, 32'h0,         32'h0,         ALU,        4'h0, 4'b1010, 4'b0000, 1'b0);
        step(4'b0010, 32'h1,         32'h1,         ALU | MW,   4'hF, 4'b1111, 4'b0000, 1'b1);
        step(4'b0000, 32'h0,         32'h0,         EE,         4'h0, 4'b1111, 4'b1111, 1'b0);
        step(4'b0100, 32'h1,         32'h2,         ALU,        4'h0, 4'b1000, 4'b1111, 1'b1);
        step(4'b0000, 32'h0,         32'h0,         ER,         4'h0, 4'b1111, 4'b1111, 1'b1);
        step(4'b0000, 32'h0,         32'h0,         MW,         4'h4, 4'b0100, 4'b1111, 1'b1);
        step(4'b0000, 32'h0,         32'h0,         EE,         4'h0, 4'b0100, 4'b0100, 1'b0);
        step(4'b0000, 32'h0,         32'h0,         MW,         4'h2, 4'b0010, 4'b0100, 1'b1);
        step(4'b0000, 32'h0,         32'h0,         EE | ER,    4'h0, 4'b0100, 4'b0010, 1'b1);
        step(4'b0000, 32'h0,         32'h0,         STL|MW|ER|EE, 4'h9, 4'b0100, 4'b0010, 1'b1);
        step(4'b0000, 32'h0,         32'h0,         MW,         4'h4, 4'b0100, 4'b0010, 1'b1);
        step(4'b0010, 32'h1,         32'h1,         ALU|FL|MW,  4'h1, 4'b0001, 4'b0010, 1'b1);
        step(4'b0101, 32'h5,         32'h3,         ALU,        4'h0, 4'b0010, 4'b0010, 1'b1);
        step(4'b0101, 32'h3,         32'h5,         ALU,        4'h0, 4'b1000, 4'b0010, 1'b1);
        step(4'b0100, 32'h8000_0000, 32'h1,         ALU,        4'h0, 4'b0011, 4'b0010, 1'b1);
        step(4'b1001, 32'h0,         32'hFFFF_FFFF, ALU,        4'h0, 4'b0111, 4'b0010, 1'b1);
        step(4'b1000, 32'h0F,        32'hF0,        ALU,        4'h0, 4'b0011, 4'b0010, 1'b1);
        step(4'b0111, 32'h0,         32'h0,         ALU,        4'h0, 4'b0111, 4'b0010, 1'b1);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, required 0", exp_q.size());

        @(negedge clk);
        {exe_valid, exe_s, exe_cond_pass, stall, flush, msr_we, exc_entry, exc_return} = ALU;
        exe_alu_cmd = 4'b0010;
        exe_a       = 32'h7FFF_FFFF;
        exe_b       = 32'h1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_status", status, 4'b0000);
        check("async_rst_shadow", shadow, 4'b0000);
        check("async_rst_flag_wr", {3'b0, flag_wr}, 4'b0000);
        @(posedge clk);
        #1;
        check("rst_hold_status", status, 4'b0000);
        check("rst_hold_flag_wr", {3'b0, flag_wr}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        {exe_valid, exe_s, exe_cond_pass} = 3'b000;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
